// File: rtl/mux_ula2_pipe.sv
// ALU operand-B source selector feeding a 2-entry valid/ready buffer.
// Immediate variants (sign/zero-extend, shifted, upper) are formed internally from the raw immediate.
module mux_ula2_pipe #(
  parameter int WIDTH     = 32,
  parameter int IMM_W     = 16,
  parameter int CONST_VAL = 4,
  parameter int SHAMT     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       seletor,
  input  logic [WIDTH-1:0] reg_b,
  input  logic [IMM_W-1:0] imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic             sel_err,
  input  logic             err_clr
);

  function automatic logic [WIDTH-1:0] decode_src(input logic [2:0]       sel,
                                                  input logic [WIDTH-1:0] rb,
                                                  input logic [IMM_W-1:0] im);
    logic signed [WIDTH-1:0] sx;
    logic [WIDTH+IMM_W-1:0]  up;
    sx = WIDTH'($signed(im));
    // Widen before shifting so the upper-immediate form truncates cleanly for any WIDTH >= IMM_W
    up = (WIDTH+IMM_W)'(im) << IMM_W;
    case (sel)
      3'b000:  decode_src = rb;
      3'b001:  decode_src = WIDTH'(CONST_VAL);
      3'b010:  decode_src = sx;
      3'b011:  decode_src = sx <<< SHAMT;
      3'b100:  decode_src = WIDTH'(im);
      3'b101:  decode_src = up[WIDTH-1:0];
      default: decode_src = '0;
    endcase
  endfunction

  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] ent0_q, ent0_d;
  logic [WIDTH-1:0] ent1_q, ent1_d;
  logic             err_q, err_d;
  logic             accept, pop, illegal;
  logic [WIDTH-1:0] src_val;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = ent0_q;
  assign occupancy = count_q;
  assign sel_err   = err_q;

  assign accept  = in_valid & in_ready;
  assign pop     = out_valid & out_ready;
  assign illegal = seletor[2] & seletor[1];
  assign src_val = decode_src(seletor, reg_b, imm);

  // ent0 is always the head; ent1 only ever holds the second entry when full
  always_comb begin
    count_d = count_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    case (count_q)
      2'd0: begin
        if (accept) begin
          ent0_d  = src_val;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (accept && pop) begin
          ent0_d = src_val;
        end else if (accept) begin
          ent1_d  = src_val;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          ent0_d  = ent1_q;
          count_d = 2'd1;
        end
      end
      default: count_d = 2'd0;
    endcase
  end

  // Set takes priority over clear when both land on the same edge
  always_comb begin
    err_d = err_q;
    if (err_clr)
      err_d = 1'b0;
    if (accept && illegal)
      err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 2'd0;
      ent0_q  <= '0;
      ent1_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      err_q   <= err_d;
    end
  end

endmodule
